// File: rtl/traffic_light_fsm_if.sv
// Lamp / vehicle-count bundle between the intersection controller and whatever
// drives it. The controller is the slave side; a bench or supervisor is the master.
interface traffic_light_fsm_if;
  logic [2:0]  vcount_northbound_i;
  logic [2:0]  vcount_southbound_i;
  logic [2:0]  vcount_eastbound_i;
  logic [2:0]  vcount_westbound_i;
  logic        ped_button_ns_i;
  logic        ped_button_ew_i;
  logic        test_mode_i;
  logic        green_northsouth_o;
  logic        yellow_northsouth_o;
  logic        red_northsouth_o;
  logic        green_eastwest_o;
  logic        yellow_eastwest_o;
  logic        red_eastwest_o;
  logic [15:0] transition_count_o;

  modport master (
    output vcount_northbound_i, vcount_southbound_i, vcount_eastbound_i, vcount_westbound_i,
    output ped_button_ns_i, ped_button_ew_i, test_mode_i,
    input  green_northsouth_o, yellow_northsouth_o, red_northsouth_o,
    input  green_eastwest_o, yellow_eastwest_o, red_eastwest_o,
    input  transition_count_o
  );

  modport slave (
    input  vcount_northbound_i, vcount_southbound_i, vcount_eastbound_i, vcount_westbound_i,
    input  ped_button_ns_i, ped_button_ew_i, test_mode_i,
    output green_northsouth_o, yellow_northsouth_o, red_northsouth_o,
    output green_eastwest_o, yellow_eastwest_o, red_eastwest_o,
    output transition_count_o
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Four-way intersection controller: NS and EW lamps sequenced through
// green / yellow / all-red, with gap-out and max-out on green, pedestrian
// request latches, a short-phase test mode and a wrapping transition counter.
module traffic_light_fsm #(
  parameter int TIMER_W      = 25,
  parameter int GREEN_MIN    = 10_000_000,
  parameter int GREEN_MAX    = 30_000_000,
  parameter int YELLOW_LEN   = 4_000_000,
  parameter int ALLRED_LEN   = 1_000_000,
  parameter int T_GREEN_MIN  = 100,
  parameter int T_GREEN_MAX  = 300,
  parameter int T_YELLOW_LEN = 40,
  parameter int T_ALLRED_LEN = 10
) (
  input  logic                clock_i,
  input  logic                reset_i,
  traffic_light_fsm_if.slave  lamp_bus
);

  typedef enum logic [2:0] {
    NS_GREEN,
    NS_YELLOW,
    ALLRED_TO_EW,
    EW_GREEN,
    EW_YELLOW,
    ALLRED_TO_NS
  } state_t;

  // Exit thresholds are stored as LEN-1 so each phase compares against the
  // last timer value it is allowed to hold.
  localparam logic [TIMER_W-1:0] GREEN_MIN_LAST    = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GREEN_MAX_LAST    = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST       = TIMER_W'(YELLOW_LEN - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LAST       = TIMER_W'(ALLRED_LEN - 1);
  localparam logic [TIMER_W-1:0] T_GREEN_MIN_LAST  = TIMER_W'(T_GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] T_GREEN_MAX_LAST  = TIMER_W'(T_GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] T_YELLOW_LAST     = TIMER_W'(T_YELLOW_LEN - 1);
  localparam logic [TIMER_W-1:0] T_ALLRED_LAST     = TIMER_W'(T_ALLRED_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE         = TIMER_W'(1);

  state_t               state;
  state_t               next_state;
  logic [TIMER_W-1:0]   timer;
  logic                 ped_ns_req;
  logic                 ped_ew_req;
  logic [15:0]          transition_count;
  logic                 green_ns, yellow_ns, red_ns;
  logic                 green_ew, yellow_ew, red_ew;

  logic [TIMER_W-1:0]   green_min_last;
  logic [TIMER_W-1:0]   green_max_last;
  logic [TIMER_W-1:0]   yellow_last;
  logic [TIMER_W-1:0]   allred_last;
  logic [3:0]           ns_sum;
  logic [3:0]           ew_sum;
  logic                 ns_cross;
  logic                 ew_cross;
  logic                 state_change;

  // Phase limits follow the live test_mode_i and demand terms are derived from
  // the current counts and latched pedestrian requests.
  always_comb begin
    green_min_last = lamp_bus.test_mode_i ? T_GREEN_MIN_LAST : GREEN_MIN_LAST;
    green_max_last = lamp_bus.test_mode_i ? T_GREEN_MAX_LAST : GREEN_MAX_LAST;
    yellow_last    = lamp_bus.test_mode_i ? T_YELLOW_LAST    : YELLOW_LAST;
    allred_last    = lamp_bus.test_mode_i ? T_ALLRED_LAST    : ALLRED_LAST;
    ns_sum   = {1'b0, lamp_bus.vcount_northbound_i} + {1'b0, lamp_bus.vcount_southbound_i};
    ew_sum   = {1'b0, lamp_bus.vcount_eastbound_i}  + {1'b0, lamp_bus.vcount_westbound_i};
    ns_cross = (ew_sum != 4'd0) || ped_ew_req;
    ew_cross = (ns_sum != 4'd0) || ped_ns_req;
  end

  // Next-state decision: greens leave on gap-out or max-out only when the
  // crossing direction wants service; yellow and all-red are fixed-length.
  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN:
        if (ns_cross && (((timer >= green_min_last) && (ns_sum == 4'd0)) ||
                         (timer >= green_max_last)))
          next_state = NS_YELLOW;
      NS_YELLOW:
        if (timer >= yellow_last) next_state = ALLRED_TO_EW;
      ALLRED_TO_EW:
        if (timer >= allred_last) next_state = EW_GREEN;
      EW_GREEN:
        if (ew_cross && (((timer >= green_min_last) && (ew_sum == 4'd0)) ||
                         (timer >= green_max_last)))
          next_state = EW_YELLOW;
      EW_YELLOW:
        if (timer >= yellow_last) next_state = ALLRED_TO_NS;
      ALLRED_TO_NS:
        if (timer >= allred_last) next_state = NS_GREEN;
      default:
        next_state = NS_GREEN;
    endcase
    state_change = (next_state != state);
  end

  // State, phase timer, pedestrian latches, counter and registered lamp decode.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state            <= NS_GREEN;
      timer            <= '0;
      ped_ns_req       <= 1'b0;
      ped_ew_req       <= 1'b0;
      transition_count <= 16'd0;
      green_ns         <= 1'b1;
      yellow_ns        <= 1'b0;
      red_ns           <= 1'b0;
      green_ew         <= 1'b0;
      yellow_ew        <= 1'b0;
      red_ew           <= 1'b1;
    end else begin
      state <= next_state;

      if (state_change) timer <= '0;
      else if (timer != '1) timer <= timer + TIMER_ONE;

      if (state_change && (next_state == NS_GREEN)) ped_ns_req <= 1'b0;
      else if (lamp_bus.ped_button_ns_i && (state != NS_GREEN)) ped_ns_req <= 1'b1;

      if (state_change && (next_state == EW_GREEN)) ped_ew_req <= 1'b0;
      else if (lamp_bus.ped_button_ew_i && (state != EW_GREEN)) ped_ew_req <= 1'b1;

      if (state_change) transition_count <= transition_count + 16'd1;

      green_ns  <= (next_state == NS_GREEN);
      yellow_ns <= (next_state == NS_YELLOW);
      red_ns    <= (next_state != NS_GREEN) && (next_state != NS_YELLOW);
      green_ew  <= (next_state == EW_GREEN);
      yellow_ew <= (next_state == EW_YELLOW);
      red_ew    <= (next_state != EW_GREEN) && (next_state != EW_YELLOW);
    end
  end

  assign lamp_bus.green_northsouth_o  = green_ns;
  assign lamp_bus.yellow_northsouth_o = yellow_ns;
  assign lamp_bus.red_northsouth_o    = red_ns;
  assign lamp_bus.green_eastwest_o    = green_ew;
  assign lamp_bus.yellow_eastwest_o   = yellow_ew;
  assign lamp_bus.red_eastwest_o      = red_ew;
  assign lamp_bus.transition_count_o  = transition_count;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: a cycle-level phase model runs alongside the
// main instance, and a second instance with one-cycle phases exercises the
// 16-bit transition counter wrap.
`timescale 1ns/1ps
module tb_traffic_light_fsm;

  localparam int T_MIN = 100;
  localparam int T_MAX = 300;
  localparam int T_YEL = 40;
  localparam int T_AR  = 10;
  localparam int N_MIN = 10_000_000;
  localparam int N_MAX = 30_000_000;
  localparam int N_YEL = 4_000_000;
  localparam int N_AR  = 1_000_000;

  // Lamp vector order: {ns green, ns yellow, ns red, ew green, ew yellow, ew red}
  localparam logic [5:0] L_NS_GREEN  = 6'b100001;
  localparam logic [5:0] L_NS_YELLOW = 6'b010001;
  localparam logic [5:0] L_ALL_RED   = 6'b001001;
  localparam logic [5:0] L_EW_GREEN  = 6'b001100;
  localparam logic [5:0] L_EW_YELLOW = 6'b001010;

  logic clock      = 1'b0;
  logic reset      = 1'b1;
  logic wrap_reset = 1'b1;

  // 1 us clock period.
  always #500 clock = ~clock;

  traffic_light_fsm_if bus();
  traffic_light_fsm_if wrap_bus();

  traffic_light_fsm dut (
    .clock_i  (clock),
    .reset_i  (reset),
    .lamp_bus (bus)
  );

  traffic_light_fsm #(
    .T_GREEN_MIN  (1),
    .T_GREEN_MAX  (1),
    .T_YELLOW_LEN (1),
    .T_ALLRED_LEN (1)
  ) wrap_dut (
    .clock_i  (clock),
    .reset_i  (wrap_reset),
    .lamp_bus (wrap_bus)
  );

  logic [5:0] dut_lamps;
  logic [5:0] wrap_lamps;
  assign dut_lamps  = {bus.green_northsouth_o, bus.yellow_northsouth_o, bus.red_northsouth_o,
                       bus.green_eastwest_o, bus.yellow_eastwest_o, bus.red_eastwest_o};
  assign wrap_lamps = {wrap_bus.green_northsouth_o, wrap_bus.yellow_northsouth_o, wrap_bus.red_northsouth_o,
                       wrap_bus.green_eastwest_o, wrap_bus.yellow_eastwest_o, wrap_bus.red_eastwest_o};

  // Phase 0..5 in travel order: NS green, NS yellow, all red, EW green, EW yellow, all red.
  logic [5:0] phase_lamps [6] = '{L_NS_GREEN, L_NS_YELLOW, L_ALL_RED, L_EW_GREEN, L_EW_YELLOW, L_ALL_RED};

  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;
  int wrap_edges   = 0;

  int m_phase   = 0;
  int m_elapsed = 0;
  int m_count   = 0;
  bit m_ped_ns  = 1'b0;
  bit m_ped_ew  = 1'b0;

  // Counts clock edges seen by the wrap instance since its reset was released.
  always @(posedge clock) if (!wrap_reset) wrap_edges <= wrap_edges + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                               input logic [2:0] w, input logic pn, input logic pe);
    bus.vcount_northbound_i = n;
    bus.vcount_southbound_i = s;
    bus.vcount_eastbound_i  = e;
    bus.vcount_westbound_i  = w;
    bus.ped_button_ns_i     = pn;
    bus.ped_button_ew_i     = pe;
  endtask

  // Advances the reference model by one clock edge using the inputs the DUT will sample.
  task automatic modelStep();
    int  g_min, g_max, yel, ar, ns_sum, ew_sum, nxt;
    bit  leave;
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_count = 0; m_ped_ns = 0; m_ped_ew = 0;
      return;
    end
    g_min  = bus.test_mode_i ? T_MIN : N_MIN;
    g_max  = bus.test_mode_i ? T_MAX : N_MAX;
    yel    = bus.test_mode_i ? T_YEL : N_YEL;
    ar     = bus.test_mode_i ? T_AR  : N_AR;
    ns_sum = int'(bus.vcount_northbound_i) + int'(bus.vcount_southbound_i);
    ew_sum = int'(bus.vcount_eastbound_i)  + int'(bus.vcount_westbound_i);
    case (m_phase)
      0: leave = (ew_sum != 0 || m_ped_ew) &&
                 ((m_elapsed >= g_min - 1 && ns_sum == 0) || m_elapsed >= g_max - 1);
      3: leave = (ns_sum != 0 || m_ped_ns) &&
                 ((m_elapsed >= g_min - 1 && ew_sum == 0) || m_elapsed >= g_max - 1);
      1, 4: leave = m_elapsed >= yel - 1;
      default: leave = m_elapsed >= ar - 1;
    endcase
    nxt = leave ? (m_phase + 1) % 6 : m_phase;
    if (leave && nxt == 0) m_ped_ns = 0;
    else if (bus.ped_button_ns_i && m_phase != 0) m_ped_ns = 1;
    if (leave && nxt == 3) m_ped_ew = 0;
    else if (bus.ped_button_ew_i && m_phase != 3) m_ped_ew = 1;
    m_elapsed = leave ? 0 : m_elapsed + 1;
    m_count   = (m_count + (leave ? 1 : 0)) % 65536;
    m_phase   = nxt;
  endtask

  task automatic stepCycle();
    bit was_reset;
    was_reset = reset;
    modelStep();
    @(posedge clock);
    @(negedge clock);
    cyc = was_reset ? 0 : cyc + 1;
    checkOutput($sformatf("model_lamps@%0d", cyc), 32'(dut_lamps), 32'(phase_lamps[m_phase]));
    checkOutput($sformatf("model_count@%0d", cyc), 32'(bus.transition_count_o), 32'(m_count));
  endtask

  task automatic runTo(input int target);
    while (cyc < target) stepCycle();
  endtask

  task automatic resetDut(input int n);
    reset = 1'b1;
    repeat (n) stepCycle();
    reset = 1'b0;
  endtask

  initial begin
    bus.test_mode_i = 1'b1;
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    wrap_bus.vcount_northbound_i = 3'd1;
    wrap_bus.vcount_southbound_i = 3'd0;
    wrap_bus.vcount_eastbound_i  = 3'd0;
    wrap_bus.vcount_westbound_i  = 3'd1;
    wrap_bus.ped_button_ns_i     = 1'b0;
    wrap_bus.ped_button_ew_i     = 1'b0;
    wrap_bus.test_mode_i         = 1'b1;
    @(negedge clock);

    $display("[TB] reset and idle hold");
    resetDut(2);
    wrap_reset = 1'b0;
    checkOutput("reset_lamps", 32'(dut_lamps), 32'(L_NS_GREEN));
    checkOutput("reset_count", 32'(bus.transition_count_o), 32'd0);
    runTo(1000);
    checkOutput("idle_lamps_1000", 32'(dut_lamps), 32'(L_NS_GREEN));
    checkOutput("idle_count_1000", 32'(bus.transition_count_o), 32'd0);

    $display("[TB] gap-out");
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0);
    resetDut(2);
    runTo(99);
    checkOutput("gap_green_99", 32'(dut_lamps), 32'(L_NS_GREEN));
    runTo(100);
    checkOutput("gap_yellow_100", 32'(dut_lamps), 32'(L_NS_YELLOW));
    checkOutput("gap_count_100", 32'(bus.transition_count_o), 32'd1);
    runTo(140);
    checkOutput("gap_allred_140", 32'(dut_lamps), 32'(L_ALL_RED));
    checkOutput("gap_count_140", 32'(bus.transition_count_o), 32'd2);
    runTo(150);
    checkOutput("gap_ewgreen_150", 32'(dut_lamps), 32'(L_EW_GREEN));
    checkOutput("gap_count_150", 32'(bus.transition_count_o), 32'd3);
    runTo(500);
    checkOutput("gap_rest_500", 32'(dut_lamps), 32'(L_EW_GREEN));

    $display("[TB] max-out");
    applyStimulus(3'd3, 3'd0, 3'd1, 3'd0, 1'b0, 1'b0);
    resetDut(2);
    runTo(299);
    checkOutput("max_green_299", 32'(dut_lamps), 32'(L_NS_GREEN));
    runTo(300);
    checkOutput("max_yellow_300", 32'(dut_lamps), 32'(L_NS_YELLOW));

    $display("[TB] pedestrian requests");
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    resetDut(2);
    runTo(10);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    runTo(100);
    checkOutput("ped_ns_yellow_100", 32'(dut_lamps), 32'(L_NS_YELLOW));
    runTo(150);
    checkOutput("ped_ew_green_150", 32'(dut_lamps), 32'(L_EW_GREEN));
    runTo(200);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    runTo(250);
    checkOutput("ped_ew_yellow_250", 32'(dut_lamps), 32'(L_EW_YELLOW));
    runTo(300);
    checkOutput("ped_ns_green_300", 32'(dut_lamps), 32'(L_NS_GREEN));
    runTo(310);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    runTo(320);
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    runTo(450);
    checkOutput("ped_ew_green_450", 32'(dut_lamps), 32'(L_EW_GREEN));
    runTo(700);
    checkOutput("ped_ignored_rest_700", 32'(dut_lamps), 32'(L_EW_GREEN));

    $display("[TB] reset during EW yellow");
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 1000 && m_phase != 4; i++) stepCycle();
    checkOutput("midreset_reach_yellow", 32'(dut_lamps), 32'(L_EW_YELLOW));
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    resetDut(1);
    checkOutput("midreset_lamps", 32'(dut_lamps), 32'(L_NS_GREEN));
    checkOutput("midreset_count", 32'(bus.transition_count_o), 32'd0);
    runTo(300);
    checkOutput("midreset_ped_cleared", 32'(dut_lamps), 32'(L_NS_GREEN));

    $display("[TB] randomized traffic");
    resetDut(2);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.vcount_northbound_i = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        bus.vcount_southbound_i = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        bus.vcount_eastbound_i  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        bus.vcount_westbound_i  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      end
      bus.ped_button_ns_i = ($urandom_range(0, 59) == 0);
      bus.ped_button_ew_i = ($urandom_range(0, 59) == 0);
      stepCycle();
    end

    $display("[TB] transition counter wrap");
    while (wrap_edges < 65535) @(negedge clock);
    checkOutput("wrap_count_ffff", 32'(wrap_bus.transition_count_o), 32'h0000FFFF);
    checkOutput("wrap_lamps_ffff", 32'(wrap_lamps), 32'(phase_lamps[65535 % 6]));
    @(negedge clock);
    checkOutput("wrap_count_0000", 32'(wrap_bus.transition_count_o), 32'h00000000);
    checkOutput("wrap_lamps_0000", 32'(wrap_lamps), 32'(phase_lamps[65536 % 6]));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Four-way intersection signal controller. Drives north-south and east-west red/yellow/green lamps from per-approach vehicle counts and pedestrian buttons. Timing is counted in clock cycles. A test mode replaces the real-time phase lengths with short ones so a bench can exercise full cycles. It is the device side of the lamp/vehicle-count interface that the Lab 3 bench stimulates and samples, and it also reports a running count of state transitions.

## Interface
- TIMER_W, 25: phase timer width (bits).
- GREEN_MIN, 10_000_000: minimum green length, cycles (normal mode).
- GREEN_MAX, 30_000_000: max-out green length, cycles (normal mode).
- YELLOW_LEN, 4_000_000: yellow length, cycles (normal mode).
- ALLRED_LEN, 1_000_000: all-red clearance length, cycles (normal mode).
- T_GREEN_MIN / T_GREEN_MAX / T_YELLOW_LEN / T_ALLRED_LEN, 100 / 300 / 40 / 10: the same four lengths in test mode.
- clock_i  in  1  system clock, rising-edge; 1 us period.
- reset_i  in  1  synchronous, active-high reset.
- vcount_northbound_i, vcount_southbound_i, vcount_eastbound_i, vcount_westbound_i  in  3 each  vehicles waiting per approach.
- ped_button_ns_i, ped_button_ew_i  in  1 each  pedestrian request for the NS / EW phase; level, any length ≥1 cycle.
- test_mode_i  in  1  1 = use the T_* lengths.
- green_northsouth_o, yellow_northsouth_o, red_northsouth_o  out  1 each  NS lamps.
- green_eastwest_o, yellow_eastwest_o, red_eastwest_o  out  1 each  EW lamps.
- transition_count_o  out  16  state changes since reset.

## Operation
- States: NS_GREEN → NS_YELLOW → ALLRED_TO_EW → EW_GREEN → EW_YELLOW → ALLRED_TO_NS → NS_GREEN. The sequence never skips a state.
- Lamps are a Moore decode of the registered state. Exactly one lamp per direction is lit.
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - EW_GREEN: EW green, NS red.
  - EW_YELLOW: EW yellow, NS red.
  - Both ALLRED states: both directions red.
- Phase timer: loads 0 on every state change, otherwise increments and saturates at all-ones.
- Lengths are chosen each cycle from the current test_mode_i. If test_mode_i changes mid-phase, the new limits apply immediately, so a timer already past the new limit exits on the next eligible edge.
- Pedestrian latches ped_ns_req and ped_ew_req:
  - Set on any cycle the button is high while the controller is not in that direction's green.
  - Cleared on the edge entering that direction's green. Clear wins over a simultaneous press.
  - A press during that direction's own green is ignored.
- Demand terms for NS_GREEN:
  - own = N+S (4-bit sum) ≠ 0.
  - cross = (E+W ≠ 0) or ped_ew_req.
  - EW_GREEN uses the same definitions mirrored.
- Green exit rule (either condition):
  - Gap-out: timer ≥ MIN−1, cross demand, and own = 0.
  - Max-out: timer ≥ MAX−1 and cross demand.
  - With no cross demand, green rests indefinitely.
- Yellow and all-red exit unconditionally when timer = LEN−1. Each lasts exactly LEN cycles.
- transition_count_o increments by 1 on every state change and wraps 0xFFFF → 0x0000.

## Timing
- Reset values: state NS_GREEN, timer 0, both ped latches 0, transition_count_o 0.
  - Lamps during and after reset: green_northsouth_o=1, red_eastwest_o=1, all others 0.
- Reset applies on any clock edge where reset_i=1, from any state, including mid-yellow and mid-all-red.
- Cycle 0 is the first cycle after reset deasserts; the timer is 0 in that cycle.
- A transition decided in cycle k shows new lamps and the incremented count in cycle k+1. There is no extra latency.
- Inputs are sampled on the rising edge and assumed synchronous; this block has no synchronizers.
- Sums are computed at 4 bits, so there is no overflow (max 7+7=14).
- A single-cycle button pulse is enough to register a request.

## Test plan
- Reset: reset_i=1 for 2 cycles, then 0 → NS green=1, EW red=1, all other lamps 0, count=0; this holds for 1000 cycles with all inputs 0.
- Gap-out (test mode): W=1, others 0 → NS_YELLOW at cycle 100 (count 1), ALLRED at 140 (count 2), EW_GREEN at 150 (count 3). The controller then rests in EW green.
- Max-out (test mode): N=3, E=1 → NS green held through cycle 299, NS yellow at 300.
- Pedestrian: all counts 0, ped_button_ew_i pulsed 1 cycle at cycle 10 → NS yellow at 100, EW green at 150. Then ped_button_ns_i pulsed at 200 → EW yellow at 250, NS green at 300. A ped_button_ns_i press during NS green causes no change.
- Reset mid-operation: reset_i=1 for 1 cycle during EW_YELLOW → next cycle NS green, EW red, count=0, ped latches clear.
- Wrap: W=1 and N=1 alternating so the controller cycles continuously in test mode until 65536 transitions → count reads 0x0000 after 0xFFFF.
